// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
// Module      : multdiv
// Description : Iterative signed multiply / divide unit for the execute stage.
//               Multiply is shift-add on magnitudes (LSB first), divide is
//               restoring division on magnitudes (MSB first). Every operation
//               takes a fixed 33 cycles from the start edge to the RDY pulse.
//
//   Ports
//     clock           in   sole clock, rising edge
//     reset           in   synchronous, active-high
//     data_operandA   in   multiplicand / dividend (two's complement)
//     data_operandB   in   multiplier / divisor (two's complement)
//     ctrl_MULT       in   start multiply (wins over ctrl_DIV)
//     ctrl_DIV        in   start divide
//     data_result     out  low word of product, or quotient
//     data_exception  out  overflow or divide-by-zero for data_result
//     data_resultRDY  out  one-cycle pulse, result/exception valid
//
// Revision    : 1.0  initial release
// ============================================================================
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [5:0]       c_LAST_STEP = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [5:0]       r_count;
    logic             r_is_mult;
    logic             r_neg;
    logic             r_div_zero;
    logic             r_div_ovf;
    logic [WIDTH-1:0] r_opnd;     // |A| for multiply, |B| for divide
    logic [WIDTH-1:0] r_hi;       // upper product word / partial remainder
    logic [WIDTH-1:0] r_lo;       // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    logic             w_start;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_prod_ovf;
    logic [WIDTH-1:0] w_quo;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right by one. The bit leaving hi enters lo.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide step: bring the next dividend bit into the remainder and try a
    // subtraction. The remainder is always below the divisor, so when the
    // trial succeeds the difference fits in WIDTH bits and modular
    // subtraction on the low bits is exact.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    assign w_prod_mag = {r_hi, r_lo};
    assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
    // Overflow when the upper word plus the low sign bit are not all equal.
    assign w_prod_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quo      = r_neg ? -r_lo : r_lo;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  w_state_next = c_IDLE;
            c_BUSY:  if (r_count == c_LAST_STEP) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        // A start in any state aborts whatever is in flight.
        if (w_start) w_state_next = c_BUSY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_count    <= 6'd0;
            r_is_mult  <= 1'b0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rdy   <= (r_state == c_DONE);

            // Completion is written even if a new start lands on this edge;
            // the start only affects the operation registers below.
            if (r_state == c_DONE) begin
                if (r_is_mult) begin
                    r_result <= w_prod[WIDTH-1:0];
                    r_exc    <= w_prod_ovf;
                end else if (r_div_zero) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                end else if (r_div_ovf) begin
                    r_result <= c_MIN_INT;
                    r_exc    <= 1'b1;
                end else begin
                    r_result <= w_quo;
                    r_exc    <= 1'b0;
                end
            end

            if (w_start) begin
                r_count    <= 6'd0;
                r_is_mult  <= ctrl_MULT;
                r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_div_zero <= (data_operandB == '0);
                r_div_ovf  <= (data_operandA == c_MIN_INT) && (&data_operandB);
                r_hi       <= '0;
                r_lo       <= ctrl_MULT ? w_mag_b : w_mag_a;
                r_opnd     <= ctrl_MULT ? w_mag_a : w_mag_b;
            end else if (r_state == c_BUSY) begin
                r_count <= r_count + 6'd1;
                if (r_is_mult) begin
                    r_hi <= w_mul_sum[WIDTH:1];
                    r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                end else begin
                    r_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv
// Description : Directed self-checking bench for multdiv: basic multiply,
//               multiply overflow, signed divide, divide-by-zero, divide
//               overflow, back-to-back start, abort and mid-operation reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks;
    int errors;

    multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start an op on the next edge, scramble operands during BUSY, then
    // wait (bounded) for RDY and capture the result plus RDY one edge later.
    task automatic do_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic exc,
                         output logic rdy_after);
        @(negedge clock);
        ctrl_MULT = mul; ctrl_DIV = ~mul;
        data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'hDEADBEEF; data_operandB = 32'h12345678;
        lat = 0; res = 32'hX; exc = 1'bX;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                lat = k; res = data_result; exc = data_exception;
                break;
            end
        end
        @(posedge clock); #1;
        rdy_after = data_resultRDY;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_op(input string name, input logic mul, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
        int lat; logic [31:0] res; logic exc; logic rdy_after;
        do_op(mul, a, b, lat, res, exc, rdy_after);
        checks++; if (lat !== 33) begin errors++; $display("FAIL %s_latency got=%0d exp=33", name, lat); end
        checks++; if (res !== exp_res) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, res, exp_res); end
        checks++; if (exc !== exp_exc) begin errors++; $display("FAIL %s_exc got=%b exp=%b", name, exc, exp_exc); end
        checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL %s_rdy_width got=%b exp=0", name, rdy_after); end
    endtask

    // Second start sampled on the edge where RDY of the first op falls.
    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd11;
        @(posedge clock); #1; ctrl_MULT = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) break;
        end
        checks++; if (data_result !== 32'd99) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", data_result, 32'd99); end
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'hFFFFFFF6; // 1000 / -10
        @(posedge clock); #1; ctrl_DIV = 1'b0;
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL b2b_rdy_fall got=%b exp=0", data_resultRDY); end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin lat = k; break; end
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        checks++; if (data_result !== 32'hFFFFFF9C) begin errors++; $display("FAIL b2b_result got=%h exp=%h", data_result, 32'hFFFFFF9C); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL b2b_exc got=%b exp=0", data_exception); end
        @(posedge clock); #1;
    endtask

    task automatic test_abort();
        int rdy_cnt; int lat; logic [31:0] res; logic exc;
        rdy_cnt = 0; lat = 0; res = 32'hX; exc = 1'bX;
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
        @(posedge clock); #1; ctrl_MULT = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_cnt++;
        end
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(posedge clock); #1; ctrl_DIV = 1'b0;
        if (data_resultRDY) rdy_cnt++;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (lat == 0) begin lat = k; res = data_result; exc = data_exception; end
            end
        end
        checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL abort_rdy_count got=%0d exp=1", rdy_cnt); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL abort_latency got=%0d exp=33", lat); end
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL abort_result got=%h exp=%h", res, 32'd14); end
        checks++; if (exc !== 1'b0) begin errors++; $display("FAIL abort_exc got=%b exp=0", exc); end
    endtask

    task automatic test_mid_reset();
        int rdy_cnt;
        rdy_cnt = 0;
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd6;
        @(posedge clock); #1; ctrl_MULT = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_cnt++;
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=%h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL midreset_exc got=%b exp=0", data_exception); end
        @(negedge clock); reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_cnt++;
        end
        checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL midreset_rdy_count got=%0d exp=0", rdy_cnt); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'h0; data_operandB = 32'h0;
        test_reset();
        test_op("mul_basic",  1'b1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        test_op("mul_ovf",    1'b1, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1);
        test_op("mul_negneg", 1'b1, 32'hFFFFFFF8,   32'hFFFFFFFB, 32'd40,       1'b0);
        test_op("div_signed", 1'b0, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 1'b0);
        test_op("div_zero",   1'b0, 32'd5,          32'd0,        32'h00000000, 1'b1);
        test_op("div_ovf",    1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1);
        test_op("div_big",    1'b0, 32'h7FFFFFFF,   32'd3,        32'h2AAAAAAA, 1'b0);
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
